// File: rtl/pio_bus_if.sv
// pio_bus_if: command/response handshake plus PIO register bus (sel/RW/addr/wdata/rdata/busy)
interface pio_bus_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_write;
    logic              rsp_err;
    logic [DATA_W-1:0] rsp_rdata;
    logic              sel;
    logic              RW;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, rdata, busy,
        output cmd_ready, rsp_valid, rsp_write, rsp_err, rsp_rdata, sel, RW, addr, wdata
    );
    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, rdata, busy,
        input  cmd_ready, rsp_valid, rsp_write, rsp_err, rsp_rdata, sel, RW, addr, wdata
    );
endinterface

// File: rtl/pio_bus_master.sv
// pio_bus_master: FIFO-buffered PIO bus initiator (clk, reset, bus: cmd in -> sel/RW/addr/wdata bus -> rsp out, busy timeout)
module pio_bus_master #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int CMD_DEPTH = 4,
    parameter int TIMEOUT   = 255
) (
    input logic       clk,
    input logic       reset,
    pio_bus_if.master bus
);
    localparam int PW = $clog2(CMD_DEPTH);
    localparam int FW = $clog2(CMD_DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, RDCAP = 2'd2, RESP = 2'd3;
    logic [1:0]        state;
    logic [FW-1:0]     count;
    logic [PW-1:0]     wp, rp;
    logic [TW-1:0]     cnt;
    logic              mem_write [CMD_DEPTH];
    logic [ADDR_W-1:0] mem_addr  [CMD_DEPTH];
    logic [DATA_W-1:0] mem_wdata [CMD_DEPTH];
    logic              push, pop, empty, done;
    assign bus.cmd_ready = count != FW'(CMD_DEPTH);
    always_comb begin
        empty = count == '0;
        push  = bus.cmd_valid && bus.cmd_ready;
        pop   = !empty && (state == IDLE || (state == RESP && bus.rsp_ready));
        done  = !bus.busy || cnt == TW'(TIMEOUT - 1);
    end
    always_ff @(posedge clk) begin
        if (push) begin
            mem_write[wp] <= bus.cmd_write;
            mem_addr[wp]  <= bus.cmd_addr;
            mem_wdata[wp] <= bus.cmd_wdata;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            count         <= '0;
            wp            <= '0;
            rp            <= '0;
            cnt           <= '0;
            bus.sel       <= 1'b0;
            bus.RW        <= 1'b0;
            bus.addr      <= '0;
            bus.wdata     <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_write <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= '0;
        end else begin
            count <= count + FW'(push) - FW'(pop);
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            case (state)
                REQ: begin
                    if (done) begin
                        bus.sel       <= 1'b0;
                        bus.RW        <= 1'b0;
                        bus.addr      <= '0;
                        bus.wdata     <= '0;
                        bus.rsp_err   <= bus.busy;
                        bus.rsp_write <= bus.RW;
                        bus.rsp_rdata <= '0;
                        bus.rsp_valid <= bus.busy || bus.RW;
                        state         <= (bus.busy || bus.RW) ? RESP : RDCAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RDCAP: begin
                    bus.rsp_rdata <= bus.rdata;
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_err   <= 1'b0;
                    bus.rsp_write <= 1'b0;
                    state         <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.rsp_write <= 1'b0;
                        bus.rsp_err   <= 1'b0;
                        bus.rsp_rdata <= '0;
                        state         <= IDLE;
                    end
                end
                default: ;
            endcase
            if (pop) begin
                state     <= REQ;
                cnt       <= '0;
                bus.sel   <= 1'b1;
                bus.RW    <= mem_write[rp];
                bus.addr  <= mem_addr[rp];
                bus.wdata <= mem_wdata[rp];
            end
        end
    end
endmodule

// File: tb/tb_pio_bus_master.sv
// tb_pio_bus_master: scoreboard bench driving pio_bus_master against a small register responder
module tb_pio_bus_master;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    pio_bus_if #(.ADDR_W(12), .DATA_W(32)) bus ();
    pio_bus_master #(.ADDR_W(12), .DATA_W(32), .CMD_DEPTH(4), .TIMEOUT(255)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );
    typedef struct packed {
        logic        write;
        logic        err;
        logic [31:0] rdata;
    } rsp_t;
    rsp_t exp_q[$];
    int tests = 0;
    int fails = 0;
    int wr_cnt = 0;
    logic [31:0] regs [0:1023];
    always @(posedge clk) begin
        if (bus.sel && !bus.busy) begin
            if (bus.RW) begin
                regs[bus.addr[11:2]] = bus.wdata;
                wr_cnt = wr_cnt + 1;
            end else begin
                bus.rdata <= regs[bus.addr[11:2]];
            end
        end
    end
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask
    always @(negedge clk) begin : monitor
        rsp_t e;
        if (!reset && bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rsp_unexpected: got response write=%0b err=%0b rdata=0x%0h with none expected", bus.rsp_write, bus.rsp_err, bus.rsp_rdata);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_write", 64'(bus.rsp_write), 64'(e.write));
                chk("rsp_err", 64'(bus.rsp_err), 64'(e.err));
                chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.rdata));
            end
        end
    end
    task automatic send(input logic w, input logic [11:0] a, input logic [31:0] d,
                        input logic expect_rsp, input logic ew, input logic ee, input logic [31:0] ed);
        bit ok;
        ok = 0;
        if (expect_rsp) exp_q.push_back('{write: ew, err: ee, rdata: ed});
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL cmd_accept: got cmd_ready=0 for 1000 cycles expected acceptance of addr 0x%0h", a);
        end
    endtask
    task automatic drain();
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain_empty", 64'(exp_q.size()), 0);
        @(posedge clk);
        #1;
    endtask
    initial begin
        int n, nv, wc;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b1;
        bus.busy      = 1'b0;
        for (int i = 0; i < 1024; i++) regs[i] = '0;
        regs[10'h032] = 32'h0001_0000;
        repeat (3) @(negedge clk);
        chk("rst_sel", 64'(bus.sel), 0);
        chk("rst_rw", 64'(bus.RW), 0);
        chk("rst_addr", 64'(bus.addr), 0);
        chk("rst_wdata", 64'(bus.wdata), 0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 0);
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        send(0, 12'h0C8, 32'h0, 1, 0, 0, 32'h0001_0000);
        @(negedge clk);
        chk("rd_n0_sel", 64'(bus.sel), 0);
        @(negedge clk);
        chk("rd_n1_sel", 64'(bus.sel), 1);
        chk("rd_n1_rw", 64'(bus.RW), 0);
        chk("rd_n1_addr", 64'(bus.addr), 64'h0C8);
        @(negedge clk);
        chk("rd_n2_sel", 64'(bus.sel), 0);
        chk("rd_n2_valid", 64'(bus.rsp_valid), 0);
        @(negedge clk);
        chk("rd_n3_valid", 64'(bus.rsp_valid), 1);
        drain();
        wc = wr_cnt;
        send(1, 12'h0C8, 32'hA5A5_0001, 1, 1, 0, 32'h0);
        @(negedge clk);
        chk("wr_n0_sel", 64'(bus.sel), 0);
        @(negedge clk);
        chk("wr_n1_sel", 64'(bus.sel), 1);
        chk("wr_n1_rw", 64'(bus.RW), 1);
        chk("wr_n1_addr", 64'(bus.addr), 64'h0C8);
        chk("wr_n1_wdata", 64'(bus.wdata), 64'hA5A5_0001);
        @(negedge clk);
        chk("wr_n2_sel", 64'(bus.sel), 0);
        chk("wr_n2_valid", 64'(bus.rsp_valid), 1);
        chk("wr_n2_addr_idle", 64'(bus.addr), 0);
        drain();
        chk("wr_count", 64'(wr_cnt - wc), 1);
        send(0, 12'h0C8, 32'h0, 1, 0, 0, 32'hA5A5_0001);
        drain();
        bus.busy = 1'b1;
        wc = wr_cnt;
        send(1, 12'h0D0, 32'h1234_5678, 1, 1, 0, 32'h0);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.sel) begin
                n++;
                chk("busy_rw", 64'(bus.RW), 1);
                chk("busy_addr", 64'(bus.addr), 64'h0D0);
                chk("busy_wdata", 64'(bus.wdata), 64'h1234_5678);
                if (n == 4) bus.busy = 1'b0;
            end
        end
        chk("busy_sel_cycles", 64'(n), 4);
        drain();
        chk("busy_wr_count", 64'(wr_cnt - wc), 1);
        send(0, 12'h0D0, 32'h0, 1, 0, 0, 32'h1234_5678);
        drain();
        bus.busy = 1'b1;
        send(0, 12'h0C8, 32'h0, 1, 0, 1, 32'h0);
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.sel) n++;
        end
        chk("tmo_sel_cycles", 64'(n), 255);
        bus.busy = 1'b0;
        drain();
        bus.rsp_ready = 1'b0;
        send(1, 12'h010, 32'h11, 1, 1, 0, 32'h0);
        send(0, 12'h010, 32'h0, 1, 0, 0, 32'h11);
        send(1, 12'h014, 32'h22, 1, 1, 0, 32'h0);
        send(0, 12'h014, 32'h0, 1, 0, 0, 32'h22);
        send(0, 12'h0C8, 32'h0, 1, 0, 0, 32'hA5A5_0001);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 12'h018;
        bus.cmd_wdata = 32'h33;
        repeat (3) begin
            @(negedge clk);
            chk("full_cmd_ready", 64'(bus.cmd_ready), 0);
            chk("held_rsp_valid", 64'(bus.rsp_valid), 1);
            chk("held_rsp_write", 64'(bus.rsp_write), 1);
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        nv = 0;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) nv++;
            if (bus.sel) n++;
        end
        chk("b2b_rsp_cycles", 64'(nv), 5);
        chk("b2b_sel_cycles", 64'(n), 4);
        drain();
        bus.busy = 1'b1;
        send(0, 12'h0C8, 32'h0, 0, 0, 0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_sel", 64'(bus.sel), 1);
        reset = 1'b1;
        #1;
        chk("mid_reset_sel", 64'(bus.sel), 0);
        chk("mid_reset_rsp_valid", 64'(bus.rsp_valid), 0);
        chk("mid_reset_cmd_ready", 64'(bus.cmd_ready), 1);
        chk("mid_reset_addr", 64'(bus.addr), 0);
        @(negedge clk);
        reset = 1'b0;
        bus.busy = 1'b0;
        @(posedge clk);
        #1;
        send(0, 12'h014, 32'h0, 1, 0, 0, 32'h22);
        drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
